// File: rtl/mipi_deserializer.sv
// MIPI D-PHY HS receive deserializer: hunts for the HS sync byte, then assembles LSB-first bytes.
// Define MIPI_RX_SYNC_TOL_EN to also accept a sync byte with a single bit error (flags HSRX_ERR_SOT).
module mipi_deserializer #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hB8
) (
  input  logic             HS_RXCLK,
  input  logic             HS_RX_RST,
  input  logic             DRXHS,
  input  logic             HS_RX_EN,
  output logic [WIDTH-1:0] HSRX_DATA,
  output logic             HSRX_VALID,
  output logic             HSRX_SOT,
  output logic             HSRX_EOT,
  output logic             HSRX_PARTIAL,
  output logic             HSRX_ACTIVE,
  output logic             HSRX_ERR_SOT
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StHunt, StRecv} state_e;

  state_e           state_q, state_d;
  logic             din_q, din_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_nxt;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             sot_q, sot_d;
  logic             eot_q, eot_d;
  logic             partial_q, partial_d;
  logic             active_q, active_d;
  logic             err_sot_q, err_sot_d;
  logic             sync_exact;
  logic             sync_tol;

  assign shift_nxt  = {din_q, shift_q[WIDTH-1:1]};
  assign sync_exact = (shift_nxt == SYNC_WORD);

`ifdef MIPI_RX_SYNC_TOL_EN
  logic [WIDTH-1:0] sync_diff;
  assign sync_diff = shift_nxt ^ SYNC_WORD;
  // Exactly one differing bit: non-zero and a power of two.
  assign sync_tol  = (sync_diff != '0) && ((sync_diff & (sync_diff - 1'b1)) == '0);
`else
  assign sync_tol  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    din_d     = DRXHS;
    shift_d   = shift_nxt;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    sot_d     = 1'b0;
    eot_d     = 1'b0;
    partial_d = 1'b0;
    err_sot_d = 1'b0;

    if (!HS_RX_EN) begin
      state_d = StIdle;
      din_d   = 1'b0;
      shift_d = '1;
      cnt_d   = '0;
      if (state_q == StRecv) begin
        eot_d     = 1'b1;
        partial_d = (cnt_q != '0);
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          // Keep the all-ones preload so the sync zeros must come from the line.
          state_d = StHunt;
          shift_d = '1;
          cnt_d   = '0;
        end
        StHunt: begin
          if (sync_exact || sync_tol) begin
            state_d   = StRecv;
            cnt_d     = '0;
            sot_d     = 1'b1;
            err_sot_d = !sync_exact;
          end
        end
        StRecv: begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            data_d  = shift_nxt;
            valid_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    active_d = (state_d == StRecv);
  end

  always_ff @(posedge HS_RXCLK) begin
    if (HS_RX_RST) begin
      state_q   <= StIdle;
      din_q     <= 1'b0;
      shift_q   <= '1;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sot_q     <= 1'b0;
      eot_q     <= 1'b0;
      partial_q <= 1'b0;
      active_q  <= 1'b0;
      err_sot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sot_q     <= sot_d;
      eot_q     <= eot_d;
      partial_q <= partial_d;
      active_q  <= active_d;
      err_sot_q <= err_sot_d;
    end
  end

  assign HSRX_DATA    = data_q;
  assign HSRX_VALID   = valid_q;
  assign HSRX_SOT     = sot_q;
  assign HSRX_EOT     = eot_q;
  assign HSRX_PARTIAL = partial_q;
  assign HSRX_ACTIVE  = active_q;
  assign HSRX_ERR_SOT = err_sot_q;

endmodule
